// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: buffers 16-bit samples and transmits them as mono-duplicated I2S frames
module i2s_sample_tx #(
    parameter int BCLK_HALF = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [15:0] sample_in,
    input  logic        sample_valid_in,
    output logic        bclk_out,
    output logic        lrclk_out,
    output logic        sdata_out,
    output logic        underrun_out,
    output logic        overrun_out
);
    localparam int DW = BCLK_HALF > 1 ? $clog2(BCLK_HALF) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_HALF - 1);

    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic [4:0]    slot_q, slot_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic [15:0]   hold_q, hold_d;
    logic          full_q, full_d;
    logic [15:0]   frame_q, frame_d;
    logic          underrun_q, underrun_d;
    logic          overrun_q, overrun_d;
    logic          tick, fall, frame_start;

    // Next state: bclk divider, slot sequencing on bclk falling edges, and buffer handoff at frame start
    always_comb begin
        tick        = div_q == DIV_MAX;
        fall        = tick && bclk_q;
        frame_start = fall && (slot_q == 5'd31);
        div_d       = tick ? '0 : div_q + DW'(1);
        bclk_d      = tick ? ~bclk_q : bclk_q;
        slot_d      = fall ? slot_q + 5'd1 : slot_q;
        frame_d     = (frame_start && full_q) ? hold_q : frame_q;
        lrclk_d     = fall ? (slot_d >= 5'd15 && slot_d <= 5'd30) : lrclk_q;
        sdata_d     = fall ? frame_d[~slot_d[3:0]] : sdata_q;
        hold_d      = sample_valid_in ? sample_in : hold_q;
        full_d      = sample_valid_in || (full_q && !frame_start);
        underrun_d  = frame_start && !full_q;
        overrun_d   = sample_valid_in && full_q && !frame_start;
    end

    // State register with synchronous reset; slot starts at 31 so the first falling edge opens slot 0
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            slot_q     <= 5'd31;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            frame_q    <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            slot_q     <= slot_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            frame_q    <= frame_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bclk_out     = bclk_q;
    assign lrclk_out    = lrclk_q;
    assign sdata_out    = sdata_q;
    assign underrun_out = underrun_q;
    assign overrun_out  = overrun_q;
endmodule
